// File: rtl/output_unit_tx.sv
// Per-port router output stage: flit FIFO from the crossbar plus the req/ack
// link FSM that streams each buffered packet HEAD..TAIL toward the neighbour.
module output_unit_tx #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [FLIT_W-1:0]        i_xbar_flit,
    input  logic                     i_xbar_valid,
    output logic                     o_xbar_ready,
    output logic                     o_downstream_req,
    input  logic                     i_transmit_ack,
    output logic [FLIT_W-1:0]        o_link_flit,
    output logic                     o_tx_busy,
    output logic                     o_pkt_sent,
    output logic                     o_proto_err,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b11;

    function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_W-2:FLIT_W-3];
    endfunction

    logic [FLIT_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nxt_s;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              req_r;
    logic              req_nxt_s;
    logic [FLIT_W-1:0] link_r;
    logic [FLIT_W-1:0] link_nxt_s;
    logic              sent_r;
    logic              sent_nxt_s;
    logic              err_r;
    logic              err_nxt_s;

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic [FLIT_W-1:0] head_s;

    assign full_s  = (count_r == FULL_CNT);
    assign empty_s = (count_r == {CW{1'b0}});
    assign head_s  = mem_r[rd_ptr_r];
    // Flits whose own valid bit is clear never occupy a FIFO slot.
    assign push_s  = i_xbar_valid && !full_s && i_xbar_flit[FLIT_W-1];

    assign o_xbar_ready     = !full_s;
    assign o_downstream_req = req_r;
    assign o_link_flit      = link_r;
    assign o_tx_busy        = (state_r != ST_IDLE);
    assign o_pkt_sent       = sent_r;
    assign o_proto_err      = err_r;
    assign o_count          = count_r;

    // Link FSM: decides pops and the next registered link outputs.
    always_comb begin
        state_nxt_s = state_r;
        req_nxt_s   = req_r;
        link_nxt_s  = {FLIT_W{1'b0}};
        sent_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_nxt_s = 1'b0;
                if (!empty_s) begin
                    if (flit_type(head_s) == TYPE_HEAD) begin
                        state_nxt_s = ST_REQ;
                        req_nxt_s   = 1'b1;
                    end else begin
                        // Orphan BODY/TAIL/NONE with no open packet is discarded.
                        pop_s     = 1'b1;
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                req_nxt_s = 1'b1;
                if (i_transmit_ack) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_SEND: begin
                req_nxt_s = 1'b1;
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    link_nxt_s = head_s;
                    if (flit_type(head_s) == TYPE_TAIL) begin
                        sent_nxt_s  = 1'b1;
                        req_nxt_s   = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_SEND;
                    end
                end else begin
                    // Stall: hold the link granted, drive an empty flit, no timeout.
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                req_nxt_s   = 1'b0;
            end
        endcase
    end

    // Occupancy update from the push/pop pair.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= i_xbar_flit;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // FSM state and registered link/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            link_r  <= {FLIT_W{1'b0}};
            sent_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            req_r   <= req_nxt_s;
            link_r  <= link_nxt_s;
            sent_r  <= sent_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_output_unit_tx.sv
// Directed bench for output_unit_tx: table-driven packet stream plus
// hand-written sequences for ack delay, full FIFO, mid-packet gaps and reset.
module tb_output_unit_tx;

    localparam int FLIT_W = 34;
    localparam int DEPTH  = 8;
    localparam int CW     = 4;

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [FLIT_W-1:0] xbar_flit;
    logic              xbar_valid;
    logic              xbar_ready;
    logic              downstream_req;
    logic              transmit_ack;
    logic [FLIT_W-1:0] link_flit;
    logic              tx_busy;
    logic              pkt_sent;
    logic              proto_err;
    logic [CW-1:0]     count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    output_unit_tx #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_xbar_flit      (xbar_flit),
        .i_xbar_valid     (xbar_valid),
        .o_xbar_ready     (xbar_ready),
        .o_downstream_req (downstream_req),
        .i_transmit_ack   (transmit_ack),
        .o_link_flit      (link_flit),
        .o_tx_busy        (tx_busy),
        .o_pkt_sent       (pkt_sent),
        .o_proto_err      (proto_err),
        .o_count          (count)
    );

    typedef struct {
        logic              v;
        logic [FLIT_W-1:0] f;
        logic              a;
        logic              ready;
        logic              req;
        logic [FLIT_W-1:0] link;
        logic              busy;
        logic              sent;
        logic              err;
        logic [CW-1:0]     cnt;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [30:0] p);
        return {1'b1, t, p};
    endfunction

    task automatic check(input string name, input logic [FLIT_W-1:0] act,
                         input logic [FLIT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive inputs for one cycle, then land on the next falling edge.
    task automatic step(input logic v, input logic [FLIT_W-1:0] f, input logic a);
        xbar_valid   = v;
        xbar_flit    = f;
        transmit_ack = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic ready, input logic req,
                              input logic [FLIT_W-1:0] link, input logic busy,
                              input logic sent, input logic err, input logic [CW-1:0] cnt);
        check({tag, ".ready"}, 34'(xbar_ready),     34'(ready));
        check({tag, ".req"},   34'(downstream_req), 34'(req));
        check({tag, ".link"},  link_flit,           link);
        check({tag, ".busy"},  34'(tx_busy),        34'(busy));
        check({tag, ".sent"},  34'(pkt_sent),       34'(sent));
        check({tag, ".err"},   34'(proto_err),      34'(err));
        check({tag, ".count"}, 34'(count),          34'(cnt));
    endtask

    logic [FLIT_W-1:0] h1, b1, b2, t1;
    logic [FLIT_W-1:0] zf;
    logic [FLIT_W-1:0] f3 [8];

    initial begin
        zf = 34'd0;
        h1 = mk(T_HEAD, 31'h0000_0A1);
        b1 = mk(T_BODY, 31'h0000_0B1);
        b2 = mk(T_BODY, 31'h0000_0B2);
        t1 = mk(T_TAIL, 31'h0000_0C1);

        // 4-flit packet, ack held high: HEAD lands, req next cycle, SEND, then stream.
        tbl[0] = '{1'b1, h1, 1'b1, 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[1] = '{1'b1, b1, 1'b1, 1'b1, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd2};
        tbl[2] = '{1'b1, b2, 1'b1, 1'b1, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd3};
        tbl[3] = '{1'b1, t1, 1'b1, 1'b1, 1'b1, h1, 1'b1, 1'b0, 1'b0, 4'd3};
        tbl[4] = '{1'b0, zf, 1'b1, 1'b1, 1'b1, b1, 1'b1, 1'b0, 1'b0, 4'd2};
        tbl[5] = '{1'b0, zf, 1'b1, 1'b1, 1'b1, b2, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[6] = '{1'b0, zf, 1'b1, 1'b1, 1'b0, t1, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[7] = '{1'b0, zf, 1'b1, 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b0, 4'd0};

        reset_n      = 1'b0;
        xbar_valid   = 1'b0;
        xbar_flit    = zf;
        transmit_ack = 1'b0;
        repeat (2) @(negedge clk);
        expect_out("reset", 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b0, 4'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].v, tbl[i].f, tbl[i].a);
            expect_out($sformatf("pkt4[%0d]", i), tbl[i].ready, tbl[i].req, tbl[i].link,
                       tbl[i].busy, tbl[i].sent, tbl[i].err, tbl[i].cnt);
        end

        // Delayed ack: req held, nothing popped, link quiet.
        step(1'b1, h1, 1'b0); expect_out("dly.h", 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b0, 4'd1);
        step(1'b1, b1, 1'b0); expect_out("dly.b1", 1'b1, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b1, b2, 1'b0); expect_out("dly.b2", 1'b1, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd3);
        step(1'b1, t1, 1'b0); expect_out("dly.t", 1'b1, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd4);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, zf, 1'b0);
            expect_out($sformatf("dly.wait%0d", i), 1'b1, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd4);
        end
        step(1'b0, zf, 1'b1); expect_out("dly.ack", 1'b1, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd4);
        step(1'b0, zf, 1'b0); expect_out("dly.s0", 1'b1, 1'b1, h1, 1'b1, 1'b0, 1'b0, 4'd3);
        step(1'b0, zf, 1'b0); expect_out("dly.s1", 1'b1, 1'b1, b1, 1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b0, zf, 1'b0); expect_out("dly.s2", 1'b1, 1'b1, b2, 1'b1, 1'b0, 1'b0, 4'd1);
        step(1'b0, zf, 1'b0); expect_out("dly.s3", 1'b1, 1'b0, t1, 1'b0, 1'b1, 1'b0, 4'd0);

        // Fill to DEPTH with ack low, attempt a 9th push, then drain in order.
        f3[0] = mk(T_HEAD, 31'h100);
        for (int i = 1; i < 7; i++) f3[i] = mk(T_BODY, 31'(32'h100 + i));
        f3[7] = mk(T_TAIL, 31'h1AA);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, f3[k], 1'b0);
            expect_out($sformatf("full.push%0d", k), (k != 7), (k != 0), zf, (k != 0),
                       1'b0, 1'b0, 4'(k + 1));
        end
        step(1'b1, mk(T_BODY, 31'h1FF), 1'b0);
        expect_out("full.ninth", 1'b0, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd8);
        step(1'b0, zf, 1'b1);
        expect_out("full.ack", 1'b0, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd8);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, zf, 1'b0);
            expect_out($sformatf("full.drain%0d", k), 1'b1, (k != 7), f3[k], (k != 7),
                       (k == 7), 1'b0, 4'(7 - k));
        end

        // Crossbar gap: FIFO runs dry mid-packet for three link cycles.
        step(1'b1, h1, 1'b1); expect_out("gap.h", 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b0, 4'd1);
        step(1'b1, b1, 1'b1); expect_out("gap.b1", 1'b1, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b0, zf, 1'b1); expect_out("gap.ack", 1'b1, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b0, zf, 1'b1); expect_out("gap.lh", 1'b1, 1'b1, h1, 1'b1, 1'b0, 1'b0, 4'd1);
        step(1'b0, zf, 1'b1); expect_out("gap.lb", 1'b1, 1'b1, b1, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, zf, 1'b1); expect_out("gap.z0", 1'b1, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, zf, 1'b1); expect_out("gap.z1", 1'b1, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, t1, 1'b1); expect_out("gap.z2", 1'b1, 1'b1, zf, 1'b1, 1'b0, 1'b0, 4'd1);
        step(1'b0, zf, 1'b1); expect_out("gap.lt", 1'b1, 1'b0, t1, 1'b0, 1'b1, 1'b0, 4'd0);

        // Orphan BODY in IDLE is dropped with one err pulse; ack in IDLE is ignored.
        step(1'b1, b2, 1'b1); expect_out("orph.push", 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b0, 4'd1);
        step(1'b0, zf, 1'b1); expect_out("orph.drop", 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, zf, 1'b1); expect_out("orph.after", 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, {1'b0, T_HEAD, 31'h55}, 1'b0);
        expect_out("inval.push", 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, zf, 1'b0);
        expect_out("inval.after", 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset after HEAD and BODY have reached the link.
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].v, tbl[i].f, tbl[i].a);
            expect_out($sformatf("rst.pre%0d", i), tbl[i].ready, tbl[i].req, tbl[i].link,
                       tbl[i].busy, tbl[i].sent, tbl[i].err, tbl[i].cnt);
        end
        xbar_valid = 1'b0;
        xbar_flit  = zf;
        #2 reset_n = 1'b0;
        #1 expect_out("rst.async", 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, zf, 1'b1); expect_out("rst.post0", 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, zf, 1'b1); expect_out("rst.post1", 1'b1, 1'b0, zf, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/output_unit_tx.md
Name: output_unit_tx

Overview:
- Per-port output stage of the router. Sits directly downstream of the crossbar/switch stage that consumes the input unit's routed flits.
- Buffers flits switched to this port and runs the req/ack link handshake toward the neighbouring router's input unit.
- Streams each packet HEAD..TAIL onto the link, one flit per cycle.
- Reports busy and completion status back to switch allocation.

Parameters:
- FLIT_W, 34, flit width in bits. Bit FLIT_W-1 is the valid bit. Bits [FLIT_W-2:FLIT_W-3] are the flit type: 00 NONE, 01 HEAD, 10 BODY, 11 TAIL.
- DEPTH, 8, output FIFO depth in flits. Power of two, minimum 2.

Ports:
- clk  in  1  single clock, all logic posedge.
- reset_n  in  1  asynchronous, active-low reset.
- i_xbar_flit  in  FLIT_W  flit from crossbar.
- i_xbar_valid  in  1  crossbar presents a flit.
- o_xbar_ready  out  1  FIFO can accept a flit; equals !full.
- o_downstream_req  out  1  link request to the downstream input unit.
- i_transmit_ack  in  1  grant from the downstream input unit.
- o_link_flit  out  FLIT_W  registered flit on the link; all zeros when idle or stalled.
- o_tx_busy  out  1  state != IDLE.
- o_pkt_sent  out  1  one-cycle pulse, coincident with the TAIL flit on o_link_flit.
- o_proto_err  out  1  one-cycle pulse when a non-HEAD flit is dropped in IDLE.
- o_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, any time including mid-packet):
  - FIFO pointers and count cleared; state IDLE.
  - All outputs 0, except o_xbar_ready = 1.
  - A partially sent packet is discarded.
- Push:
  - Occurs when i_xbar_valid && o_xbar_ready && i_xbar_flit[FLIT_W-1] == 1.
  - A flit with valid bit 0 is ignored.
  - Write takes effect at the clock edge; the flit is visible at FIFO head the next cycle.
- Pop:
  - Only from registered non-empty state.
  - Push and pop in the same cycle: count unchanged.
  - Push into an empty FIFO cannot pop in that same cycle.
  - Full: o_xbar_ready = 0; a push attempt is ignored and the count is not corrupted.
  - Pointers wrap modulo DEPTH.
- State machine: IDLE, REQ, SEND.
  - IDLE:
    - FIFO head type == HEAD -> REQ next cycle, o_downstream_req = 1 (registered).
    - FIFO head non-empty with type != HEAD -> pop it, pulse o_proto_err, stay IDLE.
    - Empty -> stay IDLE.
  - REQ:
    - Hold o_downstream_req = 1 until i_transmit_ack = 1, then enter SEND next cycle.
    - No flit is emitted in REQ.
    - An ack seen in IDLE is ignored.
  - SEND:
    - o_downstream_req stays 1.
    - Each cycle the FIFO is non-empty: pop, and register the head onto o_link_flit the next edge.
    - FIFO empty mid-packet: o_link_flit = 0, stay SEND (stall), no timeout.
    - When the popped flit is TAIL: o_link_flit = TAIL, o_pkt_sent = 1, o_downstream_req = 0, state IDLE, all on the same edge.
  - Back-to-back packets: after TAIL, IDLE evaluates the next HEAD on the following cycle. There is a minimum of one idle link cycle between packets.
- Latency: HEAD at FIFO head at cycle t -> req at t+1 -> ack sampled at cycle a -> HEAD on link at a+2.
- Single-flit packets (a lone HEAD) are not supported. A TAIL is required to close every packet.

Test Plan:
- Reset, push 4-flit packet (HEAD, BODY, BODY, TAIL), ack held 1 -> req rises 1 cycle after HEAD lands. Link shows 4 consecutive flits. o_pkt_sent pulses with TAIL; req falls; o_count returns 0.
- Delay ack 5 cycles -> req held for 5 cycles, o_link_flit stays 0, FIFO count stays 4, no pop.
- Push 8 flits with DEPTH 8 and ack 0 -> o_xbar_ready = 0, o_count = 8. 9th push ignored. After ack, drains in order, ready returns.
- Crossbar feeds BODY gaps (empty FIFO mid-packet for 3 cycles) -> o_link_flit = 0 for 3 cycles, state stays SEND, packet completes correctly.
- BODY flit pushed while IDLE -> dropped, o_proto_err pulses once, req never asserted.
- Assert reset_n = 0 after 2 flits of a 4-flit packet have been sent -> req, o_link_flit, count all 0 immediately. After release the block is IDLE with an empty FIFO.
